// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, resolves redirects from decode-stage
// signals, and holds the IF/ID register with delayed-branch semantics.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemData,
  input  logic        stall,
  input  logic        absJump,
  input  logic        absJumpLoc,
  input  logic        branch,
  input  logic        branchTaken,
  input  logic [31:0] immediateD,
  input  logic [31:0] regTarget,
  input  logic        byeD,
  output logic [31:0] instructionD,
  output logic [31:0] pcD,
  output logic        bubbleD,
  output logic        halted,
  output logic        fetchError
);

  typedef enum logic [1:0] {
    S_RUN,
    S_HALT,
    S_ERROR
  } state_t;

  state_t      state, stateNext;
  logic [31:0] pcF, pcFNext;
  logic [31:0] pcDNext;
  logic [31:0] instrNext;
  logic        bubbleNext;
  logic        haltedNext;
  logic        errorNext;
  logic [31:0] pcDPlus4;
  logic [31:0] target;

  assign imemAddr = pcF;
  assign pcDPlus4 = pcD + 32'd4;

  // Redirects only come from a valid instruction sitting in D.
  always_comb begin
    target = pcF + 32'd4;
    if (!bubbleD) begin
      if (absJump && absJumpLoc)
        target = {pcDPlus4[31:28], immediateD[25:0], 2'b00};
      else if (absJump)
        target = regTarget;
      else if (branch && branchTaken)
        target = pcDPlus4 + (immediateD << 2);
    end
  end

  always_comb begin
    stateNext  = state;
    pcFNext    = pcF;
    pcDNext    = pcD;
    instrNext  = instructionD;
    bubbleNext = bubbleD;
    haltedNext = halted;
    errorNext  = fetchError;
    case (state)
      S_RUN: begin
        if (byeD && !bubbleD) begin
          stateNext  = S_HALT;
          haltedNext = 1'b1;
          instrNext  = '0;
          bubbleNext = 1'b1;
        end else if (stall) begin
          stateNext = S_RUN;
        end else if (target[1:0] != 2'b00) begin
          stateNext  = S_ERROR;
          haltedNext = 1'b1;
          errorNext  = 1'b1;
          instrNext  = '0;
          bubbleNext = 1'b1;
        end else begin
          pcFNext    = target;
          pcDNext    = pcF;
          instrNext  = imemData;
          bubbleNext = 1'b0;
        end
      end
      default: begin
        haltedNext = 1'b1;
        instrNext  = '0;
        bubbleNext = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_RUN;
      pcF          <= RESET_PC;
      pcD          <= RESET_PC;
      instructionD <= '0;
      bubbleD      <= 1'b1;
      halted       <= 1'b0;
      fetchError   <= 1'b0;
    end else begin
      state        <= stateNext;
      pcF          <= pcFNext;
      pcD          <= pcDNext;
      instructionD <= instrNext;
      bubbleD      <= bubbleNext;
      halted       <= haltedNext;
      fetchError   <= errorNext;
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the per-stage instruction decoder. It owns the program counter and computes all redirect targets: sequential, branch, immediate jump and register jump. It drives the instruction-memory address and holds the IF/ID pipeline register that feeds `instruction`, `debugPC` and `bubble` into the decode-stage controller. Delayed-branch semantics apply: the instruction after a branch or jump (the delay slot) is always fetched and kept.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `imemAddr`  out  32  current fetch PC (`pcF`), word address in bytes.
- `imemData`  in  32  instruction at `imemAddr`, combinational read, valid same cycle.
- `stall`  in  1  from hazard unit; freezes PC and IF/ID.
- `absJump`  in  1  decode-stage controller: unconditional jump in D.
- `absJumpLoc`  in  1  1 = immediate target, 0 = register target.
- `branch`  in  1  decode-stage controller: conditional branch in D.
- `branchTaken`  in  1  branch comparison result from D (forwarded operands).
- `immediateD`  in  32  decoder immediate: 26-bit index for j/jal, sign-extended offset for beq.
- `regTarget`  in  32  forwarded rs value for jr.
- `byeD`  in  1  syscall decoded in D.
- `instructionD`  out  32  IF/ID instruction.
- `pcD`  out  32  IF/ID PC.
- `bubbleD`  out  1  IF/ID slot holds no valid instruction.
- `halted`  out  1  fetch permanently stopped, by syscall or error.
- `fetchError`  out  1  misaligned redirect target detected.

## Operation
- State machine with states RUN, HALT and ERROR. Reset enters RUN.
- Reset values:
  - `pcF` = RESET_PC, `pcD` = RESET_PC.
  - `instructionD` = 0, `bubbleD` = 1.
  - `halted` = 0, `fetchError` = 0.
- Redirect target is computed only from D-stage signals, and only when `bubbleD` = 0.
  - Immediate jump (`absJump` & `absJumpLoc`): {pcD+4 [31:28], immediateD[25:0], 2'b00}.
  - Register jump (`absJump` & !`absJumpLoc`): `regTarget`.
  - Taken branch (`branch` & `branchTaken`): pcD + 4 + (immediateD << 2), 32-bit wrap-around.
  - Otherwise: pcF + 4, wrapping at 2^32.
- RUN, per cycle, in priority order:
  1. `byeD` & !`bubbleD`: go to HALT. PC is not updated. IF/ID loads a bubble (`instructionD` = 0, `bubbleD` = 1).
  2. `stall`: PC, IF/ID and state all hold. Redirect inputs are ignored this cycle; the decoder is frozen, so they repeat next cycle.
  3. Redirect target with bits [1:0] ≠ 0: go to ERROR, set `fetchError`, IF/ID loads a bubble.
  4. Otherwise: pcF ← next target; IF/ID ← {imemData, pcF, bubbleD = 0}.
- HALT and ERROR:
  - `halted` = 1. PC holds. IF/ID loads a bubble every cycle.
  - `stall` and all redirect inputs are ignored.
  - Only reset exits either state.
- The delay-slot instruction is the one at pcD+4, already at `imemAddr` when the jump is in D. It enters IF/ID on the same edge that loads the target into the PC. Nothing is ever flushed except by halt or error.
- `halted` and `fetchError` are registered outputs, asserted the cycle after the triggering edge.

## Timing
- Fetch-to-decode latency is 1 cycle. The instruction at `imemAddr` in cycle n appears on `instructionD` in cycle n+1.
- Redirect penalty is 0 cycles beyond the architectural delay slot. The target is at `imemAddr` in the cycle after the jump leaves D.
- First valid `instructionD` (the one at RESET_PC) appears on the first edge after `reset_n` deasserts.
- Reset mid-stall, mid-halt or mid-error: reset wins on that edge and all outputs take their reset values.
- `stall` asserted together with `byeD`: halt wins.
- `stall` asserted together with a misaligned target: stall wins. The error is taken once stall drops, if the target is still misaligned.

## Test plan
- Reset: hold `reset_n` = 0 for 2 cycles, release → `imemAddr` = 0x3000, `bubbleD` = 1. Next edge: `pcD` = 0x3000, `bubbleD` = 0, `imemAddr` = 0x3004.
- Sequential plus stall: run 3 instructions, assert `stall` for 2 cycles → `imemAddr` stays at 0x300C and `instructionD` is unchanged. After release, `imemAddr` = 0x3010.
- Taken beq at pcD = 0x3010 with immediateD = 0xFFFF_FFFC → delay slot at 0x3014 enters IF/ID, then `imemAddr` = 0x3004.
- jal at pcD = 0x3020 with index 0x0000C40 → `imemAddr` = 0x0000_3100 after the delay slot at 0x3024 is latched.
- jr with `regTarget` = 0x0000_3102 → `fetchError` = 1 and `halted` = 1 next cycle. `bubbleD` stays 1 and `imemAddr` is frozen until reset.
- Syscall in D with `stall` = 1 → HALT entered anyway, `halted` = 1. Pulsing `reset_n` low for 1 cycle restores `imemAddr` = 0x3000 and `halted` = 0.
